// File: rtl/axis_packet_checksum_pkg.sv
// ============================================================================
// axis_packet_checksum_pkg : FSM encoding and byte-mask helper for stream stages
// Revision : 1.0
// ============================================================================
`default_nettype none

package axis_packet_checksum_pkg;

  typedef enum logic [1:0] {
    ST_ACCUM    = 2'd0,
    ST_SEND_SUM = 2'd1,
    ST_SEND_CNT = 2'd2
  } state_e;

  // Apply a single strobe bit to one byte lane.
  function automatic logic [7:0] byte_mask(input logic [7:0] data, input logic strb);
    return strb ? data : 8'h00;
  endfunction

endpackage

`default_nettype wire

// File: rtl/axis_packet_checksum.sv
// ============================================================================
// axis_packet_checksum : per-packet wrapping checksum + beat count, as 2-beat summary
// Revision : 1.0
// ============================================================================
`default_nettype none

module axis_packet_checksum
  import axis_packet_checksum_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 12
) (
  input  logic                    axis_aclk,
  input  logic                    axis_aresetn,
  input  logic [DATA_WIDTH-1:0]   s03_axis_tdata,
  input  logic [DATA_WIDTH/8-1:0] s03_axis_tstrb,
  input  logic                    s03_axis_tvalid,
  input  logic                    s03_axis_tlast,
  output logic                    s03_axis_tready,
  output logic [DATA_WIDTH-1:0]   m03_axis_tdata,
  output logic [DATA_WIDTH/8-1:0] m03_axis_tstrb,
  output logic                    m03_axis_tvalid,
  output logic                    m03_axis_tlast,
  input  logic                    m03_axis_tready
);

  localparam int C_STRB_W = DATA_WIDTH / 8;

  if (CNT_WIDTH > DATA_WIDTH) begin : g_bad_cnt_width
    $error("axis_packet_checksum: CNT_WIDTH must not exceed DATA_WIDTH");
  end
  if ((DATA_WIDTH % 8) != 0) begin : g_bad_data_width
    $error("axis_packet_checksum: DATA_WIDTH must be a multiple of 8");
  end

  state_e                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   sum_q, sum_d;
  logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0]    final_cnt_q, final_cnt_d;
  logic                    s_ready_q, s_ready_d;
  logic                    m_valid_q, m_valid_d;
  logic                    m_last_q, m_last_d;
  logic [DATA_WIDTH-1:0]   m_data_q, m_data_d;
  logic [C_STRB_W-1:0]     m_strb_q, m_strb_d;

  logic [DATA_WIDTH-1:0]   masked_word;
  logic [DATA_WIDTH-1:0]   sum_next;
  logic [CNT_WIDTH-1:0]    cnt_next;
  logic [DATA_WIDTH-1:0]   cnt_ext;
  logic                    accept;

  always_comb begin
    masked_word = '0;
    for (int i = 0; i < C_STRB_W; i++) begin
      masked_word[8*i +: 8] = byte_mask(s03_axis_tdata[8*i +: 8], s03_axis_tstrb[i]);
    end
  end

  assign accept   = s03_axis_tvalid & s_ready_q;
  assign sum_next = sum_q + masked_word;
  assign cnt_next = (&cnt_q) ? cnt_q : cnt_q + CNT_WIDTH'(1);

  always_comb begin
    cnt_ext = '0;
    cnt_ext[CNT_WIDTH-1:0] = final_cnt_q;
  end

  always_comb begin
    state_d     = state_q;
    sum_d       = sum_q;
    cnt_d       = cnt_q;
    final_cnt_d = final_cnt_q;
    s_ready_d   = s_ready_q;
    m_valid_d   = m_valid_q;
    m_last_d    = m_last_q;
    m_data_d    = m_data_q;
    m_strb_d    = m_strb_q;

    case (state_q)
      ST_ACCUM: begin
        s_ready_d = 1'b1;
        if (accept) begin
          if (s03_axis_tlast) begin
            // Final totals include the tlast beat; accumulators restart for the next packet.
            sum_d       = '0;
            cnt_d       = '0;
            final_cnt_d = cnt_next;
            m_data_d    = sum_next;
            m_valid_d   = 1'b1;
            m_last_d    = 1'b0;
            m_strb_d    = '1;
            s_ready_d   = 1'b0;
            state_d     = ST_SEND_SUM;
          end else begin
            sum_d = sum_next;
            cnt_d = cnt_next;
          end
        end
      end
      ST_SEND_SUM: begin
        s_ready_d = 1'b0;
        if (m03_axis_tready) begin
          m_data_d = cnt_ext;
          m_last_d = 1'b1;
          state_d  = ST_SEND_CNT;
        end
      end
      ST_SEND_CNT: begin
        s_ready_d = 1'b0;
        if (m03_axis_tready) begin
          m_valid_d = 1'b0;
          m_last_d  = 1'b0;
          m_data_d  = '0;
          m_strb_d  = '0;
          s_ready_d = 1'b1;
          state_d   = ST_ACCUM;
        end
      end
      default: begin
        state_d   = ST_ACCUM;
        sum_d     = '0;
        cnt_d     = '0;
        s_ready_d = 1'b0;
        m_valid_d = 1'b0;
        m_last_d  = 1'b0;
        m_data_d  = '0;
        m_strb_d  = '0;
      end
    endcase
  end

  always_ff @(posedge axis_aclk) begin
    if (!axis_aresetn) begin
      state_q     <= ST_ACCUM;
      sum_q       <= '0;
      cnt_q       <= '0;
      final_cnt_q <= '0;
      s_ready_q   <= 1'b0;
      m_valid_q   <= 1'b0;
      m_last_q    <= 1'b0;
      m_data_q    <= '0;
      m_strb_q    <= '0;
    end else begin
      state_q     <= state_d;
      sum_q       <= sum_d;
      cnt_q       <= cnt_d;
      final_cnt_q <= final_cnt_d;
      s_ready_q   <= s_ready_d;
      m_valid_q   <= m_valid_d;
      m_last_q    <= m_last_d;
      m_data_q    <= m_data_d;
      m_strb_q    <= m_strb_d;
    end
  end

  assign s03_axis_tready = s_ready_q;
  assign m03_axis_tvalid = m_valid_q;
  assign m03_axis_tlast  = m_last_q;
  assign m03_axis_tdata  = m_data_q;
  assign m03_axis_tstrb  = m_strb_q;

endmodule

`default_nettype wire

// File: tb/tb_axis_packet_checksum.sv
// ============================================================================
// tb_axis_packet_checksum : directed self-checking bench for axis_packet_checksum
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_axis_packet_checksum;

  logic        clk;
  logic        rstn;
  logic [31:0] s_tdata;
  logic [3:0]  s_tstrb;
  logic        s_tvalid;
  logic        s_tlast;
  logic        s_tready;
  logic [31:0] m_tdata;
  logic [3:0]  m_tstrb;
  logic        m_tvalid;
  logic        m_tlast;
  logic        m_tready;

  int vectors;
  int miscompares;

  axis_packet_checksum #(
    .DATA_WIDTH (32),
    .CNT_WIDTH  (12)
  ) dut (
    .axis_aclk       (clk),
    .axis_aresetn    (rstn),
    .s03_axis_tdata  (s_tdata),
    .s03_axis_tstrb  (s_tstrb),
    .s03_axis_tvalid (s_tvalid),
    .s03_axis_tlast  (s_tlast),
    .s03_axis_tready (s_tready),
    .m03_axis_tdata  (m_tdata),
    .m03_axis_tstrb  (m_tstrb),
    .m03_axis_tvalid (m_tvalid),
    .m03_axis_tlast  (m_tlast),
    .m03_axis_tready (m_tready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one beat just after a falling edge; it is accepted on the next rising edge.
  task automatic send_beat(input logic [31:0] d, input logic [3:0] s, input logic l);
    s_tdata  = d;
    s_tstrb  = s;
    s_tlast  = l;
    s_tvalid = 1'b1;
    chk("s_tready_on_beat", {31'd0, s_tready}, 32'd1);
    @(negedge clk);
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  // With m_tready held high: sum beat, count beat, then idle with input reopened.
  task automatic expect_summary(input string tag, input logic [31:0] sum, input logic [31:0] cnt);
    chk({tag, "_sum_valid"}, {31'd0, m_tvalid}, 32'd1);
    chk({tag, "_sum_data"},  m_tdata, sum);
    chk({tag, "_sum_last"},  {31'd0, m_tlast}, 32'd0);
    chk({tag, "_sum_strb"},  {28'd0, m_tstrb}, 32'hF);
    chk({tag, "_sum_tready"}, {31'd0, s_tready}, 32'd0);
    @(negedge clk);
    chk({tag, "_cnt_valid"}, {31'd0, m_tvalid}, 32'd1);
    chk({tag, "_cnt_data"},  m_tdata, cnt);
    chk({tag, "_cnt_last"},  {31'd0, m_tlast}, 32'd1);
    chk({tag, "_cnt_tready"}, {31'd0, s_tready}, 32'd0);
    @(negedge clk);
    chk({tag, "_idle_valid"}, {31'd0, m_tvalid}, 32'd0);
    chk({tag, "_idle_last"},  {31'd0, m_tlast}, 32'd0);
    chk({tag, "_idle_tready"}, {31'd0, s_tready}, 32'd1);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rstn     = 1'b0;
    s_tdata  = '0;
    s_tstrb  = '0;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    m_tready = 1'b1;

    // Reset held for three rising edges
    repeat (3) @(negedge clk);
    chk("rst_tready", {31'd0, s_tready}, 32'd0);
    chk("rst_mvalid", {31'd0, m_tvalid}, 32'd0);
    chk("rst_mlast",  {31'd0, m_tlast},  32'd0);
    chk("rst_mdata",  m_tdata, 32'd0);
    chk("rst_mstrb",  {28'd0, m_tstrb}, 32'd0);
    rstn = 1'b1;
    @(negedge clk);
    chk("post_rst_tready", {31'd0, s_tready}, 32'd1);

    // Four-beat packet 1,2,3,4
    send_beat(32'd1, 4'hF, 1'b0);
    send_beat(32'd2, 4'hF, 1'b0);
    send_beat(32'd3, 4'hF, 1'b0);
    send_beat(32'd4, 4'hF, 1'b1);
    expect_summary("pkt4", 32'd10, 32'd4);

    // Strobe masking on a single-beat packet
    send_beat(32'hAABBCCDD, 4'b0101, 1'b1);
    expect_summary("strb", 32'h00BB00DD, 32'd1);

    // Modular wrap
    send_beat(32'hFFFFFFFF, 4'hF, 1'b0);
    send_beat(32'h00000002, 4'hF, 1'b1);
    expect_summary("wrap", 32'h00000001, 32'd2);

    // All-zero strobe still counts
    send_beat(32'd3, 4'hF, 1'b0);
    send_beat(32'h0000FFFF, 4'h0, 1'b0);
    send_beat(32'd4, 4'hF, 1'b1);
    expect_summary("zstrb", 32'd7, 32'd3);

    // Back-pressure with a pending input beat held valid throughout
    m_tready = 1'b0;
    send_beat(32'd7, 4'hF, 1'b1);
    s_tdata  = 32'h100;
    s_tstrb  = 4'hF;
    s_tlast  = 1'b1;
    s_tvalid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_sum_valid",  {31'd0, m_tvalid}, 32'd1);
      chk("bp_sum_data",   m_tdata, 32'd7);
      chk("bp_sum_last",   {31'd0, m_tlast}, 32'd0);
      chk("bp_sum_tready", {31'd0, s_tready}, 32'd0);
      @(negedge clk);
    end
    m_tready = 1'b1;
    @(negedge clk);
    m_tready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk("bp_cnt_data",   m_tdata, 32'd1);
      chk("bp_cnt_last",   {31'd0, m_tlast}, 32'd1);
      chk("bp_cnt_valid",  {31'd0, m_tvalid}, 32'd1);
      chk("bp_cnt_tready", {31'd0, s_tready}, 32'd0);
      @(negedge clk);
    end
    m_tready = 1'b1;
    @(negedge clk);
    chk("bp_reopen_tready", {31'd0, s_tready}, 32'd1);
    chk("bp_reopen_mvalid", {31'd0, m_tvalid}, 32'd0);
    @(negedge clk);
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    expect_summary("held", 32'h100, 32'd1);

    // Reset in the middle of a packet discards the partial sums
    send_beat(32'd9, 4'hF, 1'b0);
    send_beat(32'd10, 4'hF, 1'b0);
    rstn = 1'b0;
    @(negedge clk);
    chk("midrst_tready", {31'd0, s_tready}, 32'd0);
    chk("midrst_mvalid", {31'd0, m_tvalid}, 32'd0);
    rstn = 1'b1;
    @(negedge clk);
    send_beat(32'd5, 4'hF, 1'b1);
    expect_summary("midrst", 32'd5, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
